// File: rtl/sprite_seq_pkg.sv
// Shared types and default parameter values for the sprite ROM sequencer.
package sprite_seq_pkg;

   localparam int N_REQ_DEF   = 4;
   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 4;
   localparam int LEN_W_DEF   = 6;
   localparam int ROM_LAT_DEF = 1;
   // Wide enough for the largest supported requester count (8).
   localparam int ID_W_MAX    = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
      logic                last;
   } pipe_ent_t;

endpackage

// File: rtl/sprite_rr_pick.sv
// Combinational winner select: first asserted req searching upward from an origin with wrap.
// Origin is the round-robin pointer, or fixed at 0 when SPRITE_SEQ_FIXED_PRI_EN is defined.
module sprite_rr_pick
   import sprite_seq_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = $clog2(N_REQ_DEF)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] win_oh,
   output logic [ID_W-1:0]  win_idx,
   output logic             win_any
);

   int origin;
   int idx;

`ifdef SPRITE_SEQ_FIXED_PRI_EN
   assign origin = 0;
`else
   assign origin = int'(ptr);
`endif

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      win_any = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (origin + i) % N_REQ;
         if (!win_any && req[idx]) begin
            win_any     = 1'b1;
            win_idx     = ID_W'(idx);
            win_oh[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_rom_sequencer.sv
// Arbitrates burst reads of one shared sprite ROM and returns tagged read data.
// Define SPRITE_SEQ_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module sprite_rom_sequencer
   import sprite_seq_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int ROM_LAT = ROM_LAT_DEF
) (
   input  logic                      vga_clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   base_addr,
   input  logic [N_REQ*LEN_W-1:0]    burst_len,
   output logic [N_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]         rom_address,
   input  logic [DATA_W-1:0]         rom_q,
   output logic                      rd_valid,
   output logic [$clog2(N_REQ)-1:0]  rd_id,
   output logic                      rd_last,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      busy
);

   localparam int ID_W = $clog2(N_REQ);

   // Handshake: req is a level held until the one-cycle gnt pulse; base_addr and
   // burst_len are sampled on the grant decision edge only; dropping req earlier withdraws it.

   seq_state_t       state, state_nxt;
   logic [ID_W-1:0]  ptr, cur_id, win_idx;
   logic [N_REQ-1:0] win_oh;
   logic             win_any, load, issue, last_word, in_flight;
   logic [LEN_W-1:0] count;
   pipe_ent_t        issue_ent;
   pipe_ent_t        pipe [ROM_LAT];

   sprite_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .win_any (win_any)
   );

   assign last_word = (count == '0);

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (win_any) begin
               load      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (last_word) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         gnt         <= '0;
         rom_address <= '0;
         count       <= '0;
         cur_id      <= '0;
      end else begin
         gnt <= load ? win_oh : '0;
         if (load) begin
            rom_address <= base_addr[win_idx*ADDR_W +: ADDR_W];
            count       <= burst_len[win_idx*LEN_W +: LEN_W];
            cur_id      <= win_idx;
         end else if (issue) begin
            rom_address <= rom_address + ADDR_W'(1);
            count       <= count - LEN_W'(1);
         end
      end
   end

`ifdef SPRITE_SEQ_FIXED_PRI_EN
   assign ptr = '0;
`else
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset)     ptr <= '0;
      else if (load) ptr <= (win_idx == ID_W'(N_REQ-1)) ? '0 : win_idx + ID_W'(1);
   end
`endif

   always_comb begin
      issue_ent       = '0;
      issue_ent.valid = issue;
      issue_ent.id    = ID_W_MAX'(cur_id);
      issue_ent.last  = last_word;
   end

   // Tag pipeline tracks ROM latency so tags line up with rom_q.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= issue_ent;
         for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      in_flight = 1'b0;
      for (int i = 0; i < ROM_LAT; i++) in_flight = in_flight | pipe[i].valid;
   end

   assign busy     = (state == ISSUE) | in_flight;
   assign rd_valid = pipe[ROM_LAT-1].valid;
   assign rd_id    = ID_W'(pipe[ROM_LAT-1].id);
   assign rd_last  = pipe[ROM_LAT-1].last;
   assign rd_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_sequencer.sv
// Bench for sprite_rom_sequencer: ROM_LAT=1 and ROM_LAT=3 instances share stimulus and
// are checked every cycle against a transaction-level model of grants, addresses and reads.
module tb_sprite_rom_sequencer;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 4;
   localparam int LW = 6;
   localparam int QW = 40;

   logic          vga_clk = 1'b0;
   logic          reset   = 1'b1;
   logic [N-1:0]    req       = '0;
   logic [N*AW-1:0] base_addr = '0;
   logic [N*LW-1:0] burst_len = '0;

   logic [N-1:0]  gnt1, gnt3;
   logic [AW-1:0] addr1, addr3;
   logic [DW-1:0] rom_q1, rom_q3, r3a, r3b;
   logic          rd_valid1, rd_valid3, rd_last1, rd_last3, busy1, busy3;
   logic [1:0]    rd_id1, rd_id3;
   logic [DW-1:0] rd_data1, rd_data3;

   logic [DW-1:0] mem [1024];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // ---------------- clock ----------------
   always #5 vga_clk = ~vga_clk;

   sprite_rom_sequencer #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ROM_LAT(1)) u_dut1 (
      .vga_clk(vga_clk), .reset(reset), .req(req), .base_addr(base_addr), .burst_len(burst_len),
      .gnt(gnt1), .rom_address(addr1), .rom_q(rom_q1), .rd_valid(rd_valid1), .rd_id(rd_id1),
      .rd_last(rd_last1), .rd_data(rd_data1), .busy(busy1)
   );

   sprite_rom_sequencer #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ROM_LAT(3)) u_dut3 (
      .vga_clk(vga_clk), .reset(reset), .req(req), .base_addr(base_addr), .burst_len(burst_len),
      .gnt(gnt3), .rom_address(addr3), .rom_q(rom_q3), .rd_valid(rd_valid3), .rd_id(rd_id3),
      .rd_last(rd_last3), .rd_data(rd_data3), .busy(busy3)
   );

   // Synchronous ROMs with 1 and 3 cycles of latency.
   always @(posedge vga_clk) rom_q1 <= mem[addr1];
   always @(posedge vga_clk) begin
      r3a    <= mem[addr3];
      r3b    <= r3a;
      rom_q3 <= r3b;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [QW-1:0] exp_q1[$];
   logic [QW-1:0] exp_q3[$];
   logic [N-1:0]  m_gnt       = '0;
   logic [AW-1:0] m_addr      = '0;
   int            m_ptr       = 0;
   int            blocked     = 0;
   int            busy_until1 = -1;
   int            busy_until3 = -1;

   always @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         exp_q1.delete();
         exp_q3.delete();
         m_gnt = '0; m_addr = '0; m_ptr = 0; blocked = 0;
         busy_until1 = -1; busy_until3 = -1;
      end else begin
         cyc++;
         m_gnt = '0;
         if (blocked > 0) begin
            m_addr = m_addr + 1'b1;
            blocked--;
         end else if (req != '0) begin
            int w, b, l, a;
            w = -1;
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (w < 0 && req[j]) w = j;
            end
            b = int'(base_addr[w*AW +: AW]);
            l = int'(burst_len[w*LW +: LW]);
            m_gnt[w] = 1'b1;
            m_addr   = AW'(b);
            blocked  = l + 1;
`ifndef SPRITE_SEQ_FIXED_PRI_EN
            m_ptr = (w + 1) % N;
`endif
            for (int k = 0; k <= l; k++) begin
               a = (b + k) % 1024;
               exp_q1.push_back({32'(cyc + k + 1), 3'(w), (k == l), mem[a]});
               exp_q3.push_back({32'(cyc + k + 3), 3'(w), (k == l), mem[a]});
            end
            busy_until1 = cyc + l + 1;
            busy_until3 = cyc + l + 3;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int gnt_log[$];

   always @(negedge vga_clk) begin
      logic [QW-1:0] ent;
      check("gnt1", 32'(gnt1), 32'(m_gnt));
      check("gnt3", 32'(gnt3), 32'(m_gnt));
      check("addr1", 32'(addr1), 32'(m_addr));
      check("addr3", 32'(addr3), 32'(m_addr));
      check("busy1", 32'(busy1), 32'(cyc <= busy_until1));
      check("busy3", 32'(busy3), 32'(cyc <= busy_until3));
      if (reset) begin
         check("rst_id1", 32'(rd_id1), 0);
         check("rst_last1", 32'(rd_last1), 0);
         check("rst_id3", 32'(rd_id3), 0);
         check("rst_last3", 32'(rd_last3), 0);
      end
      ent = '0;
      if (exp_q1.size() != 0) ent = exp_q1[0];
      if (exp_q1.size() != 0 && ent[39:8] == 32'(cyc)) begin
         void'(exp_q1.pop_front());
         check("rd_valid1", 32'(rd_valid1), 1);
         check("rd_id1", 32'(rd_id1), 32'(ent[7:5]));
         check("rd_last1", 32'(rd_last1), 32'(ent[4]));
         check("rd_data1", 32'(rd_data1), 32'(ent[3:0]));
      end else begin
         check("rd_valid1", 32'(rd_valid1), 0);
      end
      ent = '0;
      if (exp_q3.size() != 0) ent = exp_q3[0];
      if (exp_q3.size() != 0 && ent[39:8] == 32'(cyc)) begin
         void'(exp_q3.pop_front());
         check("rd_valid3", 32'(rd_valid3), 1);
         check("rd_id3", 32'(rd_id3), 32'(ent[7:5]));
         check("rd_last3", 32'(rd_last3), 32'(ent[4]));
         check("rd_data3", 32'(rd_data3), 32'(ent[3:0]));
      end else begin
         check("rd_valid3", 32'(rd_valid3), 0);
      end
      for (int i = 0; i < N; i++) if (gnt1[i]) gnt_log.push_back(i);
   end

   // ---------------- driver tasks ----------------
   task automatic set_burst(input int i, input int base, input int len);
      base_addr[i*AW +: AW] = AW'(base);
      burst_len[i*LW +: LW] = LW'(len);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge vga_clk);
   endtask

   task automatic wait_gnt(input int i);
      logic got;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge vga_clk);
         if (gnt1[i]) got = 1'b1;
      end
      check("wait_gnt", 32'(got), 1);
   endtask

   task automatic wait_log(input int n);
      for (int k = 0; k < 400 && gnt_log.size() < n; k++) @(negedge vga_clk);
      check("log_len", 32'(gnt_log.size() >= n), 1);
   endtask

   task automatic rand_step();
      for (int i = 0; i < N; i++) begin
         if (req[i] && gnt1[i])            req[i] = ($urandom_range(0, 3) == 0);
         else if (!req[i])                 req[i] = ($urandom_range(0, 5) == 0);
         else if ($urandom_range(0, 40) == 0) req[i] = 1'b0;
         if ($urandom_range(0, 3) == 0)
            set_burst(i, int'($urandom_range(0, 1023)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                  : int'($urandom_range(0, 5)));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int exp_rr[5];
      int exp_pri[4];
      for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom_range(0, 15));
`ifdef SPRITE_SEQ_FIXED_PRI_EN
      exp_rr  = '{0, 0, 0, 0, 0};
      exp_pri = '{1, 1, 1, 1};
`else
      exp_rr  = '{0, 1, 2, 3, 0};
      exp_pri = '{1, 3, 1, 3};
`endif
      idle(3);
      #1 reset = 1'b0;
      idle(2);

      // contention, all requesters held, len 1 each
      gnt_log.delete();
      for (int i = 0; i < N; i++) set_burst(i, 64 * i + 5, 1);
      req = 4'b1111;
      wait_log(5);
      req = '0;
      for (int k = 0; k < 5 && k < gnt_log.size(); k++) check("rr_order", 32'(gnt_log[k]), 32'(exp_rr[k]));
      idle(8);

      // single burst
      set_burst(0, 'h010, 3);
      req[0] = 1'b1;
      wait_gnt(0);
      req[0] = 1'b0;
      idle(8);

      // address wrap
      set_burst(2, 'h3FE, 3);
      req[2] = 1'b1;
      wait_gnt(2);
      req[2] = 1'b0;
      idle(8);

      // reset during the 2nd address of a burst
      set_burst(1, 'h100, 7);
      req[1] = 1'b1;
      wait_gnt(1);
      req[1] = 1'b0;
      @(posedge vga_clk);
      #2 reset = 1'b1;
      #1;
      check("arst_gnt", 32'(gnt1), 0);
      check("arst_valid1", 32'(rd_valid1), 0);
      check("arst_valid3", 32'(rd_valid3), 0);
      check("arst_busy1", 32'(busy1), 0);
      check("arst_busy3", 32'(busy3), 0);
      check("arst_addr", 32'(addr1), 0);
      @(negedge vga_clk);
      #1 reset = 1'b0;
      idle(4);
      gnt_log.delete();
      req = 4'b1111;
      wait_log(1);
      req = '0;
      if (gnt_log.size() > 0) check("post_rst_gnt", 32'(gnt_log[0]), 0);
      idle(12);

      // single-word burst
      set_burst(3, 'h055, 0);
      req[3] = 1'b1;
      wait_gnt(3);
      req[3] = 1'b0;
      idle(8);

      // priority between requesters 1 and 3
      gnt_log.delete();
      set_burst(1, 'h200, 2);
      set_burst(3, 'h300, 2);
      req = 4'b1010;
      wait_log(4);
      req = '0;
      for (int k = 0; k < 4 && k < gnt_log.size(); k++) check("pri_order", 32'(gnt_log[k]), 32'(exp_pri[k]));
      idle(10);

      // randomized traffic with occasional asynchronous resets
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(300, 500)) begin
            @(negedge vga_clk);
            rand_step();
         end
         @(posedge vga_clk);
         #2 reset = 1'b1;
         @(negedge vga_clk);
         #1 reset = 1'b0;
      end
      repeat (400) begin
         @(negedge vga_clk);
         rand_step();
      end
      req = '0;
      idle(150);
      check("drain1", 32'(exp_q1.size()), 0);
      check("drain3", 32'(exp_q3.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_rom_sequencer.md
Name: sprite_rom_sequencer

Overview:
- Shares one synchronous sprite ROM (address in, palette index out) between N_REQ sprite requesters: tank bodies, turrets, bullets, HUD.
- Each requester asks for a burst of consecutive ROM words, typically one sprite row, to fill its line buffer during horizontal blanking.
- The block arbitrates between requesters, drives the ROM address one word per cycle, and returns each word tagged with requester id and a last flag.
- Sits between the per-sprite line-buffer fillers and the single ROM instance in the vga_clk domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, ROM address width.
- DATA_W, 4, ROM word width (palette index).
- LEN_W, 6, burst length field width. The field holds count-1, so the maximum burst is 2^LEN_W words.
- ROM_LAT, 1, cycles from a registered address to valid rom_q (1..4).

Ports:
- vga_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester burst request, level-sensitive.
- base_addr  in  N_REQ*ADDR_W  per-requester start address, packed with requester i at bits [i*ADDR_W +: ADDR_W].
- burst_len  in  N_REQ*LEN_W  per-requester word count minus 1, packed the same way.
- gnt  out  N_REQ  one-hot, one-cycle pulse when a burst starts.
- rom_address  out  ADDR_W  registered address to the ROM.
- rom_q  in  DATA_W  ROM read data.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_id  out  $clog2(N_REQ)  owner of rd_data.
- rd_last  out  1  final word of a burst.
- rd_data  out  DATA_W  rom_q passed through, aligned with rd_valid.
- busy  out  1  high while in ISSUE or while any read is in flight.

Behaviour:
- Reset values: state IDLE, gnt 0, rom_address 0, rd_valid 0, rd_id 0, rd_last 0, busy 0, all pipeline valids 0, round-robin pointer 0.
- FSM has two states: IDLE and ISSUE.
- IDLE:
  - If any req is high at edge t, pick a winner w round-robin, searching from the pointer upward with wrap.
  - At t+1: state ISSUE, gnt[w]=1 for exactly this cycle, rom_address=base_addr[w], count=burst_len[w], cur_id=w, pointer=(w+1) mod N_REQ.
  - base_addr and burst_len are sampled only at the decision edge; later changes are ignored.
- ISSUE:
  - Each cycle, issue rom_address into the read pipeline, then increment the address mod 2^ADDR_W (wraps 0x3FF to 0x000 at ADDR_W=10) and decrement count.
  - When count==0 the current word is last; next state is IDLE.
  - There is a mandatory one-cycle IDLE bubble between bursts. Back-to-back grants never occur.
- req rules:
  - A requester holds req until it sees gnt.
  - If req is still high after the burst ends, it is a new request and competes normally.
  - Dropping req before gnt withdraws the request silently.
- Read pipeline:
  - A shift register of depth ROM_LAT carries {valid, id, last}.
  - An address registered in cycle c yields rd_valid, rd_id, rd_last in cycle c+ROM_LAT.
  - rd_data = rom_q combinationally.
- busy stays high until the last rd_valid has been produced.
- Reset asserted mid-burst: all outputs return to reset values immediately, including in-flight valids. No rd_valid appears after release until a new grant.
- burst_len 0 gives exactly one read, with rd_last on that read.

Optional Feature:
- Macro: SPRITE_SEQ_FIXED_PRI_EN.
- Defined: fixed priority, lowest index wins. The pointer register is removed and is always 0.
- Undefined: round-robin as described above.

Decomposition:
- Package sprite_seq_pkg holds:
  - state enum seq_state_t {IDLE, ISSUE};
  - pipeline entry struct {valid, id, last};
  - default localparams for the parameters above.
- One sub-module, sprite_rr_pick: combinational winner select from req and the pointer, producing a one-hot winner and its index. The macro switches its search origin.

Test Plan:
- Single burst, ROM_LAT=1, req[0] with base 0x010, len 3: gnt[0] pulses once; rom_address 0x010, 0x011, 0x012, 0x013 on consecutive cycles; 4 rd_valid cycles starting 1 cycle after the first address; rd_id 0; rd_last on the 4th only.
- Contention: req=4'b1111 held continuously, each len 1: grant order 0,1,2,3,0; exactly one idle cycle between bursts; rd_id sequence matches the grants.
- Wrap: base 0x3FE, len 3: addresses 0x3FE, 0x3FF, 0x000, 0x001; rd_data matches the ROM model.
- Reset mid-burst: reset asserted during the 2nd address: gnt, rd_valid and busy go to 0 asynchronously; no stray rd_valid after release; the next grant goes to requester 0.
- Latency: ROM_LAT=3 instance, len 0: one rd_valid with rd_last exactly 3 cycles after the address; busy deasserts the following cycle.
- Priority: req[1] and req[3] held continuously:
  - macro undefined: grants alternate 1,3,1,3;
  - SPRITE_SEQ_FIXED_PRI_EN defined: grants are always 1.
